keymap_ctrl: RTL and testbench

//  Sequences lookups into the 2KB keymap ROM. Consumes the PS/2 scancode byte stream and tracks
//  E0 (long) and F0 (break) prefixes and the shift, ctrl and caps-lock state. Forms the ROM address,

---
 rtl/keymap_pkg.sv | 31 +++
 rtl/keymap_ctrl_char_fifo.sv | 54 +++++
 rtl/keymap_ctrl.sv | 136 +++++++++++++
 tb/tb_keymap_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/keymap_pkg.sv
// Shared constants, FSM state type and helpers for the PS/2 keymap controller.
package keymap_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned ADDR_W = 11;

  localparam logic [CODE_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [CODE_W-1:0] SC_BRK    = 8'hF0;
  localparam logic [CODE_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [CODE_W-1:0] SC_CAPS   = 8'h58;

  localparam int unsigned ADDR_LONG  = 10;
  localparam int unsigned ADDR_CAPS  = 9;
  localparam int unsigned ADDR_SHIFT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // Ctrl folds the 0x40..0x7F range down onto control codes 0x00..0x1F.
  function automatic logic [CODE_W-1:0] ctrl_mask(input logic [CODE_W-1:0] c,
                                                  input logic ctrl);
    if (ctrl && (c[7:6] == 2'b01)) return c & 8'h1F;
    return c;
  endfunction

endpackage

// File: rtl/keymap_ctrl_char_fifo.sv
// First-word-fall-through character queue; a push into a full queue is taken only alongside a pop.
module char_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Storage carries no reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keymap_ctrl.sv
// PS/2 scancode to ASCII controller: prefix/modifier tracking, keymap ROM sequencing, output queue.
module keymap_ctrl
  import keymap_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] scan_code,
  input  logic              scan_valid,
  output logic              scan_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CODE_W-1:0] rom_dout,
  output logic [CODE_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              caps_led,
  output logic              overflow
);

  state_t            state, state_d;
  logic              long_pend, long_d;
  logic              brk_pend, brk_d;
  logic              lshift, lshift_d;
  logic              rshift, rshift_d;
  logic              lctrl, lctrl_d;
  logic              rctrl, rctrl_d;
  logic              caps, caps_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q;
  logic              accept;
  logic              push;
  logic              fifo_full;
  logic [CODE_W-1:0] c_masked;

  assign accept     = scan_valid && ready_q;
  assign scan_ready = ready_q;
  assign rom_addr   = addr_q;
  assign caps_led   = caps;
  assign c_masked   = ctrl_mask(rom_dout, lctrl || rctrl);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      long_pend <= 1'b0;
      brk_pend  <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      caps      <= 1'b0;
      addr_q    <= '0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_d;
      long_pend <= long_d;
      brk_pend  <= brk_d;
      lshift    <= lshift_d;
      rshift    <= rshift_d;
      lctrl     <= lctrl_d;
      rctrl     <= rctrl_d;
      caps      <= caps_d;
      addr_q    <= addr_d;
      ready_q   <= (state_d == IDLE);
    end
  end

  // Byte decode in IDLE, then a fixed LOOKUP/EMIT pair per character key.
  always_comb begin
    state_d  = state;
    long_d   = long_pend;
    brk_d    = brk_pend;
    lshift_d = lshift;
    rshift_d = rshift;
    lctrl_d  = lctrl;
    rctrl_d  = rctrl;
    caps_d   = caps;
    addr_d   = addr_q;
    push     = 1'b0;
    overflow = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (scan_code == SC_EXT) begin
            long_d = 1'b1;
          end else if (scan_code == SC_BRK) begin
            brk_d = 1'b1;
          end else begin
            long_d = 1'b0;
            brk_d  = 1'b0;
            if (!long_pend && scan_code == SC_LSHIFT) begin
              lshift_d = !brk_pend;
            end else if (!long_pend && scan_code == SC_RSHIFT) begin
              rshift_d = !brk_pend;
            end else if (scan_code == SC_CTRL) begin
              if (long_pend) rctrl_d = !brk_pend;
              else           lctrl_d = !brk_pend;
            end else if (scan_code == SC_CAPS) begin
              if (!brk_pend) caps_d = !caps;
            end else if (!brk_pend) begin
              addr_d             = {3'b000, scan_code};
              addr_d[ADDR_LONG]  = long_pend;
              addr_d[ADDR_CAPS]  = caps;
              addr_d[ADDR_SHIFT] = lshift || rshift;
              state_d            = LOOKUP;
            end
          end
        end
      end
      LOOKUP: state_d = EMIT;
      EMIT: begin
        state_d = IDLE;
        if (c_masked != '0) begin
          if (fifo_full && !char_ready) overflow = 1'b1;
          else                          push     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  char_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (c_masked),
    .pop     (char_ready),
    .dout    (char_out),
    .valid   (char_valid),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_keymap_ctrl.sv
// Directed bench for keymap_ctrl with a registered keymap ROM model.
module tb_keymap_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  scan_code = 8'h00;
  logic        scan_valid = 1'b0;
  logic        scan_ready;
  logic [10:0] rom_addr;
  logic [7:0]  rom_dout;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1'b1;
  logic        caps_led;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keymap_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .scan_ready (scan_ready),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .caps_led   (caps_led),
    .overflow   (overflow)
  );

  // Registered ROM: data = code ^ {long,caps,shift}; zero where they coincide.
  always_ff @(posedge clk) begin
    rom_dout <= rom_addr[7:0] ^ {5'b00000, rom_addr[10:8]};
  end

  // Returns just after the accepting clock edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!scan_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!scan_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: scan_ready=%b required 1 for byte %h", scan_ready, b);
    end
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
  endtask

  // Character key with an empty queue and char_ready=1.
  task automatic key(input logic [7:0] code, input logic [10:0] exp_addr,
                     input logic exp_push, input logic [7:0] exp_char);
    send_byte(code);
    vectors++;
    if (rom_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL rom_addr[%h]: got %h expected %h", code, rom_addr, exp_addr);
    end
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (char_valid !== exp_push) begin
      miscompares++;
      $display("FAIL char_valid[%h]: got %b expected %b", code, char_valid, exp_push);
    end
    if (exp_push) begin
      vectors++;
      if (char_out !== exp_char) begin
        miscompares++;
        $display("FAIL char_out[%h]: got %h expected %h", code, char_out, exp_char);
      end
    end
  endtask

  // Byte that must not start a lookup.
  task automatic no_char(input logic [7:0] code);
    send_byte(code);
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (char_valid !== 1'b0 || scan_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL no_char[%h]: char_valid=%b scan_ready=%b expected 0/1", code, char_valid, scan_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({scan_ready, rom_addr, char_valid, char_out, caps_led, overflow} !== {1'b1, 11'h000, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b addr=%h cv=%b co=%h caps=%b ovf=%b expected 1/000/0/00/0/0",
               scan_ready, rom_addr, char_valid, char_out, caps_led, overflow);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    key(8'h1C, 11'h01C, 1'b1, 8'h1C);
    send_byte(8'hF0);
    no_char(8'h1C);
  endtask

  task automatic test_shift();
    send_byte(8'h12);
    key(8'h1C, 11'h11C, 1'b1, 8'h1D);
    send_byte(8'hF0);
    send_byte(8'h12);
    key(8'h1C, 11'h01C, 1'b1, 8'h1C);
  endtask

  task automatic test_caps();
    send_byte(8'h58);
    send_byte(8'hF0);
    send_byte(8'h58);
    vectors++;
    if (caps_led !== 1'b1) begin
      miscompares++;
      $display("FAIL caps_on: got %b expected 1", caps_led);
    end
    key(8'h1C, 11'h21C, 1'b1, 8'h1E);
    send_byte(8'h58);
    vectors++;
    if (caps_led !== 1'b0) begin
      miscompares++;
      $display("FAIL caps_off: got %b expected 0", caps_led);
    end
  endtask

  task automatic test_long_ctrl();
    send_byte(8'hE0);
    key(8'h75, 11'h475, 1'b1, 8'h71);
    send_byte(8'hE0);
    send_byte(8'h14);
    key(8'h61, 11'h061, 1'b1, 8'h01);
    key(8'h00, 11'h000, 1'b0, 8'h00);
    key(8'h31, 11'h031, 1'b1, 8'h31);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h14);
    key(8'h61, 11'h061, 1'b1, 8'h61);
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    char_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'(8'h21 + i));
      @(posedge clk); #1;
      vectors++;
      if (overflow !== (i == 4)) begin
        miscompares++;
        $display("FAIL overflow[%0d]: got %b expected %b", i, overflow, (i == 4));
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_pulse: got %b expected 0", overflow);
    end
    char_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (char_valid !== 1'b1 || char_out !== 8'(8'h21 + i)) begin
        miscompares++;
        $display("FAIL pop[%0d]: valid=%b char=%h expected 1/%h", i, char_valid, char_out, 8'(8'h21 + i));
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (char_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drained: char_valid=%b expected 0", char_valid);
    end
  endtask

  task automatic test_reset_mid();
    char_ready = 1'b0;
    send_byte(8'h58);
    send_byte(8'h31);
    repeat (2) begin @(posedge clk); #1; end
    send_byte(8'h32);
    repeat (2) begin @(posedge clk); #1; end
    send_byte(8'h33);
    vectors++;
    if (caps_led !== 1'b1 || rom_addr !== 11'h233 || char_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: caps=%b addr=%h cv=%b expected 1/233/1", caps_led, rom_addr, char_valid);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (char_valid !== 1'b0 || caps_led !== 1'b0 || rom_addr !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_mid: cv=%b caps=%b addr=%h expected 0/0/000", char_valid, caps_led, rom_addr);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (char_valid !== 1'b0 || scan_ready !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: cv=%b rdy=%b ovf=%b expected 0/1/0", char_valid, scan_ready, overflow);
    end
    char_ready = 1'b1;
    key(8'h1C, 11'h01C, 1'b1, 8'h1C);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_caps();
    test_long_ctrl();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
